// File: rtl/usb_phy_pkg.sv
// Shared definitions for the USB PHY receive path.
// Line-state encodings from the line decoder, receive framing FSM states,
// and the framing error codes reported on err_code.
package usb_phy_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALT,
    ST_ACTIVE,
    ST_EOP,
    ST_BABBLE
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SE1    = 2'b01,
    ERR_BABBLE = 2'b10,
    ERR_EOP    = 2'b11
  } err_code_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_sync_eop_detector_if.sv
// Bit-rate interface between the DPLL/line decoder and the SYNC/EOP framer.
//   sample_en     : one strobe per recovered bit
//   line_state    : decoded line state (SE0/J/K/SE1)
//   hs_mode       : selects the HS SYNC threshold
//   sync_detected : pulse on SYNC completion
//   rx_active     : packet in progress
//   eop_detected  : pulse on valid EOP
//   rx_error      : pulse on framing error
//   err_code      : last error code
// master = line decoder side, slave = framer.
interface usb_sync_eop_detector_if;
  logic       sample_en;
  logic [1:0] line_state;
  logic       hs_mode;
  logic       sync_detected;
  logic       rx_active;
  logic       eop_detected;
  logic       rx_error;
  logic [1:0] err_code;

  modport master (
    output sample_en, line_state, hs_mode,
    input  sync_detected, rx_active, eop_detected, rx_error, err_code
  );

  modport slave (
    input  sample_en, line_state, hs_mode,
    output sync_detected, rx_active, eop_detected, rx_error, err_code
  );
endinterface

// File: rtl/usb_sat_counter.sv
// Saturating up-counter used for the framer's run-length counters.
//   clk, reset : clock, async active-high reset
//   clr_i      : clear; with en_i also high the counter loads 1 (the
//                current sample is the first one of a new run)
//   en_i       : increment, holding at MAX
//   cnt_o      : current count
//   at_max_o   : count equals MAX
module usb_sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = en_i ? W'(1) : '0;
    else if (en_i && !at_max_o) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/usb_sync_eop_detector.sv
// USB receive framing FSM: SYNC search (FS/HS threshold), packet tracking,
// EOP detection, SE1 / babble / bad-EOP error reporting.
//   clk, reset : bit-domain clock, async active-high reset
//   bus        : slave side of usb_sync_eop_detector_if
// The FSM only advances on sample_en; all outputs are registered so each
// pulse appears one cycle after the edge that sampled its symbol.
module usb_sync_eop_detector
  import usb_phy_pkg::*;
#(
  parameter int FS_MIN_ALT   = 7,
  parameter int HS_MIN_ALT   = 11,
  parameter int EOP_MIN_SE0  = 2,
  parameter int EOP_MAX_SE0  = 8,
  parameter int MAX_PKT_BITS = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  usb_sync_eop_detector_if.slave  bus
);
  localparam int ALT_MAX = max_int(FS_MIN_ALT, HS_MIN_ALT);
  localparam int ALT_W   = $clog2(ALT_MAX + 1);
  localparam int BIT_W   = $clog2(MAX_PKT_BITS + 1);
  localparam int SE0_W   = $clog2(EOP_MAX_SE0 + 1);

  rx_state_e   state_q, state_d;
  logic        last_k_q, last_k_d;
  logic        hs_q, hs_d;
  logic        sync_q, sync_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        active_q, active_d;

  logic             alt_clr, alt_en, bit_clr, bit_en, se0_clr, se0_en;
  logic [ALT_W-1:0] alt_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [SE0_W-1:0] se0_cnt;
  logic             alt_at_max, bit_at_max, se0_at_max;
  logic             unused_at_max;

  usb_sat_counter #(.MAX(ALT_MAX), .W(ALT_W)) u_alt_cnt (
    .clk(clk), .reset(reset), .clr_i(alt_clr), .en_i(alt_en),
    .cnt_o(alt_cnt), .at_max_o(alt_at_max)
  );
  usb_sat_counter #(.MAX(MAX_PKT_BITS), .W(BIT_W)) u_bit_cnt (
    .clk(clk), .reset(reset), .clr_i(bit_clr), .en_i(bit_en),
    .cnt_o(bit_cnt), .at_max_o(bit_at_max)
  );
  usb_sat_counter #(.MAX(EOP_MAX_SE0), .W(SE0_W)) u_se0_cnt (
    .clk(clk), .reset(reset), .clr_i(se0_clr), .en_i(se0_en),
    .cnt_o(se0_cnt), .at_max_o(se0_at_max)
  );
  // Thresholds are compared explicitly below; the saturation flags are spare.
  assign unused_at_max = alt_at_max ^ bit_at_max ^ se0_at_max;

  line_state_e      ls;
  logic             se, is_j, is_k, is_se0, is_se1;
  logic [ALT_W-1:0] min_alt;
  logic             alt_ok, opposite, babble_hit, se0_last, eop_ok;

  assign ls     = line_state_e'(bus.line_state);
  assign se     = bus.sample_en;
  assign is_j   = (ls == LS_J);
  assign is_k   = (ls == LS_K);
  assign is_se0 = (ls == LS_SE0);
  assign is_se1 = (ls == LS_SE1);

  assign min_alt    = hs_q ? ALT_W'(HS_MIN_ALT) : ALT_W'(FS_MIN_ALT);
  assign alt_ok     = (alt_cnt >= min_alt);
  assign opposite   = (is_k && !last_k_q) || (is_j && last_k_q);
  assign babble_hit = (bit_cnt == BIT_W'(MAX_PKT_BITS - 1));
  // The SE0 being sampled now brings the run to EOP_MAX_SE0.
  assign se0_last   = (se0_cnt >= SE0_W'(EOP_MAX_SE0 - 1));
  assign eop_ok     = (se0_cnt >= SE0_W'(EOP_MIN_SE0));

  // State register (plus registered outputs and latched context)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_k_q <= 1'b0;
      hs_q     <= 1'b0;
      sync_q   <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_k_q <= last_k_d;
      hs_q     <= hs_d;
      sync_q   <= sync_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
      code_q   <= code_d;
      active_q <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (se) begin
      unique case (state_q)
        ST_IDLE:   if (is_k) state_d = ST_ALT;
        ST_ALT: begin
          if (opposite)           state_d = ST_ALT;
          else if (is_k && alt_ok) state_d = ST_ACTIVE;
          else                    state_d = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (is_se0)          state_d = ST_EOP;
          else if (is_se1)     state_d = ST_IDLE;
          else if (babble_hit) state_d = ST_BABBLE;
        end
        ST_EOP:    if (!is_se0 || se0_last) state_d = ST_IDLE;
        // se0_cnt tracks the SE0 run while babbling; J after SE0 releases.
        ST_BABBLE: if (is_j && se0_cnt != '0) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath control
  always_comb begin
    last_k_d = last_k_q;
    hs_d     = hs_q;
    sync_d   = 1'b0;
    eop_d    = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    alt_clr  = 1'b0;
    alt_en   = 1'b0;
    bit_clr  = 1'b0;
    bit_en   = 1'b0;
    se0_clr  = 1'b0;
    se0_en   = 1'b0;
    active_d = se ? (state_d == ST_ACTIVE || state_d == ST_EOP) : active_q;
    if (se) begin
      unique case (state_q)
        ST_IDLE: if (is_k) begin
          alt_clr  = 1'b1;
          alt_en   = 1'b1;
          last_k_d = 1'b1;
          hs_d     = bus.hs_mode;
        end
        ST_ALT: begin
          if (opposite) begin
            alt_en   = !alt_ok;  // hold at the active threshold
            last_k_d = is_k;
          end else if (is_k && alt_ok) begin
            sync_d  = 1'b1;
            bit_clr = 1'b1;
          end
        end
        ST_ACTIVE: begin
          bit_en = 1'b1;
          if (is_se0) begin
            se0_clr = 1'b1;
            se0_en  = 1'b1;
          end else if (is_se1) begin
            err_d  = 1'b1;
            code_d = ERR_SE1;
          end else if (babble_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_BABBLE;
            se0_clr = 1'b1;
          end
        end
        ST_EOP: begin
          if (is_se0) begin
            se0_en = 1'b1;
            if (se0_last) begin
              err_d  = 1'b1;
              code_d = ERR_EOP;
            end
          end else if (is_j && eop_ok) begin
            eop_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_EOP;
          end
        end
        ST_BABBLE: begin
          se0_clr = !is_se0;
          se0_en  = is_se0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sync_detected = sync_q;
  assign bus.rx_active     = active_q;
  assign bus.eop_detected  = eop_q;
  assign bus.rx_error      = err_q;
  assign bus.err_code      = code_q;
endmodule
